// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-issue MIPS pipeline.
// Owns the PC, drives the combinational instruction memory and captures the
// returned word into the IF/ID register. Handles stall, branch/jump redirect
// (squashing the wrong-path fetch), halt, and a saturating fetch counter.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   pc                  registered word address to instruction memory
//   instruction         word returned by memory for pc (same cycle)
//   stall               hold pc and IF/ID
//   branch_taken        taken branch in ID; target = if_id_pc_plus1 + offset
//   branch_offset       sign-extended branch immediate (words)
//   jump, jump_target   absolute jump in ID
//   halt_req            stop fetching (exits only on rst)
//   if_id_instruction   IF/ID instruction word
//   if_id_pc_plus1      IF/ID address of fetched word + 1
//   if_id_valid         IF/ID holds a real instruction
//   halted              fetch stopped
//   fetch_count         saturating count of instructions delivered to IF/ID
module fetch_unit #(
  parameter logic [7:0]  RESET_PC    = 8'd0,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [7:0]             pc,
  input  logic [31:0]            instruction,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [15:0]            branch_offset,
  input  logic                   jump,
  input  logic [7:0]             jump_target,
  input  logic                   halt_req,
  output logic [31:0]            if_id_instruction,
  output logic [7:0]             if_id_pc_plus1,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t                 state, state_next;
  logic [7:0]             pc_next;
  logic [31:0]            ins_next;
  logic [7:0]             pc_plus1_next;
  logic                   valid_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   redirect;

  // Only the low byte of the offset matters with 8-bit modulo addressing.
  logic unused_offset_hi;
  assign unused_offset_hi = ^branch_offset[15:8];

  assign redirect = branch_taken | jump;
  assign halted   = (state == HALT);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ins_next      = if_id_instruction;
    pc_plus1_next = if_id_pc_plus1;
    valid_next    = if_id_valid;
    count_next    = fetch_count;
    case (state)
      RUN: begin
        // PC update: redirect beats stall; branch beats jump.
        if (branch_taken)
          pc_next = if_id_pc_plus1 + branch_offset[7:0];
        else if (jump)
          pc_next = jump_target;
        else if (!stall)
          pc_next = pc + 8'd1;

        // IF/ID update: halt and redirect both load a bubble.
        if (halt_req || redirect) begin
          ins_next      = '0;
          pc_plus1_next = '0;
          valid_next    = 1'b0;
          if (halt_req)
            state_next = HALT;
        end else if (!stall) begin
          ins_next      = instruction;
          pc_plus1_next = pc + 8'd1;
          valid_next    = 1'b1;
          if (fetch_count != '1)
            count_next = fetch_count + COUNT_WIDTH'(1);
        end
      end
      HALT: begin
        ins_next      = '0;
        pc_plus1_next = '0;
        valid_next    = 1'b0;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      pc                <= RESET_PC;
      if_id_instruction <= '0;
      if_id_pc_plus1    <= '0;
      if_id_valid       <= 1'b0;
      fetch_count       <= '0;
    end else begin
      state             <= state_next;
      pc                <= pc_next;
      if_id_instruction <= ins_next;
      if_id_pc_plus1    <= pc_plus1_next;
      if_id_valid       <= valid_next;
      fetch_count       <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus with a scoreboard queue of
// expected post-edge states and a monitor process that compares after each
// rising edge. A narrow counter width makes saturation reachable.
module tb_fetch_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    pc;
  logic [31:0]   instruction;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [15:0]   branch_offset = '0;
  logic          jump = 1'b0;
  logic [7:0]    jump_target = '0;
  logic          halt_req = 1'b0;
  logic [31:0]   if_id_instruction;
  logic [7:0]    if_id_pc_plus1;
  logic          if_id_valid;
  logic          halted;
  logic [CW-1:0] fetch_count;

  fetch_unit #(.RESET_PC(8'd0), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .halt_req(halt_req),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: tagged word so a real word never looks like a bubble.
  assign instruction = 32'hC000_0000 | {24'd0, pc};

  typedef struct {
    logic [7:0]    pc;
    logic [31:0]   ins;
    logic [7:0]    p1;
    logic          v;
    logic          h;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (value after the most recent edge).
  logic [7:0]    m_pc  = '0;
  logic [31:0]   m_ins = '0;
  logic [7:0]    m_p1  = '0;
  logic          m_v   = 1'b0;
  logic          m_h   = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per edge, compared shortly after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc",       {24'd0, pc},                e.pc);
      check("if_id_ins", if_id_instruction,          e.ins);
      check("if_id_p1", {24'd0, if_id_pc_plus1},    e.p1);
      check("valid",    {31'd0, if_id_valid},       e.v);
      check("halted",   {31'd0, halted},            e.h);
      check("count",    {{(32-CW){1'b0}}, fetch_count}, e.cnt);
    end
  end

  // Drive one edge worth of inputs (at negedge), predict and push the result.
  task automatic step(input logic r, input logic st, input logic br,
                      input logic [15:0] off, input logic jp,
                      input logic [7:0] tgt, input logic hr);
    logic [7:0] npc;
    exp_t e;
    rst = r; stall = st; branch_taken = br; branch_offset = off;
    jump = jp; jump_target = tgt; halt_req = hr;
    if (r) begin
      m_pc = 8'd0; m_ins = '0; m_p1 = '0; m_v = 1'b0; m_h = 1'b0; m_cnt = '0;
    end else if (m_h) begin
      m_ins = '0; m_p1 = '0; m_v = 1'b0;
    end else begin
      if (br)       npc = m_p1 + off[7:0];
      else if (jp)  npc = tgt;
      else if (st)  npc = m_pc;
      else          npc = m_pc + 8'd1;
      if (hr || br || jp) begin
        m_ins = '0; m_p1 = '0; m_v = 1'b0;
        if (hr) m_h = 1'b1;
      end else if (!st) begin
        m_ins = 32'hC000_0000 | {24'd0, m_pc};
        m_p1  = m_pc + 8'd1;
        m_v   = 1'b1;
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
      m_pc = npc;
    end
    e.pc = m_pc; e.ins = m_ins; e.p1 = m_p1; e.v = m_v; e.h = m_h; e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic normal(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 8'h0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 16'h0, 0, 8'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset and sequential fetch.
    do_reset();
    check("rst_pc",    {24'd0, pc}, 32'd0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    normal(10);
    check("seq_count", {{(32-CW){1'b0}}, fetch_count}, 32'd10);
    check("seq_pc",    {24'd0, pc}, 32'd10);

    // Stall at pc=5 for 3 edges, then release.
    do_reset();
    normal(5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, 0, 8'h0, 0);
    check("stall_pc",    {24'd0, pc}, 32'd5);
    check("stall_ins",   if_id_instruction, 32'hC000_0004);
    check("stall_count", {{(32-CW){1'b0}}, fetch_count}, 32'd5);
    normal(1);
    check("release_ins", if_id_instruction, 32'hC000_0005);

    // Branch forward with pc_plus1=5, offset 2.
    do_reset();
    normal(5);
    step(0, 0, 1, 16'h0002, 0, 8'h0, 0);
    check("br_pc",    {24'd0, pc}, 32'd7);
    check("br_valid", {31'd0, if_id_valid}, 32'd0);
    normal(1);
    check("br_target_ins", if_id_instruction, 32'hC000_0007);

    // Branch backward: 5 + (-5) = 0.
    do_reset();
    normal(5);
    step(0, 0, 1, 16'hFFFB, 0, 8'h0, 0);
    check("br_back_pc", {24'd0, pc}, 32'd0);

    // Jump, then branch+jump priority, then redirect over stall.
    step(0, 0, 0, 16'h0, 1, 8'h20, 0);
    check("jump_pc", {24'd0, pc}, 32'h20);
    do_reset();
    normal(9);
    step(0, 0, 1, 16'h0001, 1, 8'h33, 0);
    check("br_jump_pc", {24'd0, pc}, 32'd10);
    step(0, 1, 0, 16'h0, 1, 8'h40, 0);
    check("redir_stall_pc", {24'd0, pc}, 32'h40);

    // Wrap from 254, and counter saturation.
    step(0, 0, 0, 16'h0, 1, 8'd254, 0);
    normal(2);
    check("wrap_pc", {24'd0, pc}, 32'd0);
    check("wrap_p1", {24'd0, if_id_pc_plus1}, 32'd0);
    normal(20);
    check("sat_count", {{(32-CW){1'b0}}, fetch_count}, 32'd15);

    // Halt at pc=3, then ignored controls, then reset.
    do_reset();
    normal(3);
    step(0, 0, 0, 16'h0, 0, 8'h0, 1);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc",   {24'd0, pc}, 32'd4);
    for (int i = 0; i < 20; i++)
      step(0, i[0], i[1], 16'h0003, i[2], 8'h55, i[3]);
    check("halt_pc_frozen",    {24'd0, pc}, 32'd4);
    check("halt_count_frozen", {{(32-CW){1'b0}}, fetch_count}, 32'd3);
    check("halt_valid",        {31'd0, if_id_valid}, 32'd0);
    do_reset();
    check("unhalt_flag",  {31'd0, halted}, 32'd0);
    check("unhalt_pc",    {24'd0, pc}, 32'd0);
    check("unhalt_count", {{(32-CW){1'b0}}, fetch_count}, 32'd0);
    normal(1);
    check("post_rst_valid", {31'd0, if_id_valid}, 32'd1);

    if (q.size() != 0) check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue MIPS pipeline. Owns the program counter, drives the word address into the combinational instruction memory and captures the returned word into the IF/ID pipeline register. Also applies stalls, branch/jump redirects with squash of the wrong-path fetch, and a halt request, and keeps a saturating count of fetched instructions.

## Interface
- RESET_PC, 8'd0, PC value loaded on reset (word address)
- COUNT_WIDTH, 16, width of fetch_count
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- pc  output  8  word address to instruction memory (registered)
- instruction  input  32  word returned by instruction memory for pc (same cycle, combinational)
- stall  input  1  hazard unit: hold pc and IF/ID
- branch_taken  input  1  decode stage: taken beq/bne in ID
- branch_offset  input  16  sign-extended immediate of that branch (words)
- jump  input  1  decode stage: jump in ID
- jump_target  input  8  absolute jump word address
- halt_req  input  1  request to stop fetching
- if_id_instruction  output  32  IF/ID instruction
- if_id_pc_plus1  output  8  IF/ID address of fetched word + 1
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- halted  output  1  fetch stopped
- fetch_count  output  COUNT_WIDTH  instructions delivered to IF/ID

## Operation
- States: RUN, HALT. Reset enters RUN. HALT exits only on rst.
- Per-edge priority in RUN: rst > redirect > stall > normal.
- Normal: pc <= pc+1; if_id_instruction <= instruction; if_id_pc_plus1 <= pc+1; if_id_valid <= 1; fetch_count += 1.
- Stall (no redirect): pc, IF/ID, fetch_count all hold.
- Redirect = branch_taken | jump. Redirect overrides stall.
  - branch_taken: pc <= if_id_pc_plus1 + branch_offset[7:0] (mod 256).
  - jump only: pc <= jump_target. If both are asserted, the branch wins.
  - IF/ID squashed: if_id_valid <= 0, if_id_instruction <= 0, if_id_pc_plus1 <= 0. fetch_count holds.
  - Redirect is accepted regardless of if_id_valid.
- halt_req in RUN: the pc update for that edge (normal/stall/redirect) still applies. IF/ID loads a bubble, state <= HALT.
- HALT: pc holds. IF/ID emits bubbles (valid 0, instruction 0). fetch_count frozen. stall, redirect and halt_req are ignored. halted = 1.
- Arithmetic:
  - pc and target additions are 8-bit modulo; 255+1 wraps to 0 with no flag.
  - fetch_count saturates at 2^COUNT_WIDTH-1.

## Timing
- Reset values:
  - pc = RESET_PC.
  - if_id_instruction = 0, if_id_pc_plus1 = 0, if_id_valid = 0.
  - halted = 0, fetch_count = 0, state RUN.
- Fetch latency:
  - The word at address A appears on if_id_* one edge after pc = A.
  - After rst deasserts, if_id_valid first rises on the next edge, carrying word RESET_PC.
- Redirect:
  - Resolved in ID; the single wrong-path word in IF is squashed.
  - pc = target on the edge after redirect is sampled.
  - The target word is in IF/ID one edge later.
  - Net penalty: 1 bubble.
- halted rises on the edge that samples halt_req. The bubble appears on the same edge.
- rst asserted mid-operation (including in HALT) restores all reset values on that edge.
- Inputs are sampled only at the rising clk edge. Nothing is combinational from inputs to outputs.

## Test plan
- Sequential fetch: rst 1 cycle, memory returns word=addr.
  - Expect if_id_pc_plus1 = 1,2,3… with instruction 0,1,2…, valid 1.
  - After 10 edges, fetch_count = 10.
- Stall: stall high 3 cycles with pc=5.
  - pc stays 5 and IF/ID holds word 4 for 3 edges; fetch_count unchanged.
  - Release: word 5 loads next edge.
- Branch: branch_taken with if_id_pc_plus1=5, offset 16'h0002 → pc=7, next IF/ID valid=0.
  - Following edge loads word 7.
  - Offset 16'hFFFB with pc_plus1=5 → pc=0.
- Jump and priority:
  - jump with target 8'h20 → pc=0x20.
  - jump+branch_taken together (pc_plus1=9, offset 1) → pc=10.
  - redirect+stall together → redirect applied.
- Wrap: run from pc=254 → pc 255 then 0; if_id_pc_plus1 = 255 then 0.
- Halt:
  - halt_req at pc=3 → halted=1, pc=4 frozen, valid stays 0, fetch_count frozen for 20 cycles.
  - Later stall/jump are ignored.
  - rst returns pc=0, halted=0, fetch_count=0.
